// File: rtl/i2s_receiver_pkg.sv
// Shared audio package: PCM word defaults, I2S slot counter width and the
// receiver FSM state encoding.
package i2s_receiver_pkg;

    // Default PCM sample width used across the audio path.
    localparam int unsigned PCM_AUDIO_BITS = 16;

    // I2S bit-in-slot counter width; it saturates at its all-ones value.
    localparam int unsigned I2S_SLOT_CNT_W = 6;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

    // Saturating increment of the slot bit counter.
    function automatic logic [I2S_SLOT_CNT_W-1:0] slot_cnt_inc(
        input logic [I2S_SLOT_CNT_W-1:0] cnt
    );
        return (cnt == '1) ? cnt : I2S_SLOT_CNT_W'(cnt + 1'b1);
    endfunction

endpackage

// File: rtl/i2s_receiver_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
//   clk     : destination clock
//   reset_n : asynchronous reset, active low
//   d       : asynchronous input
//   q       : synchronized output
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in clk, frames left/right words
// and delivers them as a PCM pair once a full left-then-right frame is seen.
//   clk       : system clock, >= 4x BCLK
//   reset_n   : asynchronous reset, active low
//   bclk      : I2S bit clock (async)
//   lrclk     : I2S word select, 0 = left, 1 = right (async)
//   sdata     : I2S serial data, MSB first (async)
//   pcm_l     : last complete left sample
//   pcm_r     : last complete right sample
//   valid     : one-clk pulse when pcm_l/pcm_r update
//   frame_err : one-clk pulse on short word or slot overrun
//   locked    : high while the framer is not hunting
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int unsigned audio_bits = PCM_AUDIO_BITS,
    parameter int unsigned slot_max   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [audio_bits-1:0] pcm_l,
    output logic [audio_bits-1:0] pcm_r,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  locked
);

    localparam int unsigned CW = I2S_SLOT_CNT_W;

    logic bclk_s, lr_s, sd_s;

    sync2 u_sync_bclk (.clk(clk), .reset_n(reset_n), .d(bclk),  .q(bclk_s));
    sync2 u_sync_lr   (.clk(clk), .reset_n(reset_n), .d(lrclk), .q(lr_s));
    sync2 u_sync_sd   (.clk(clk), .reset_n(reset_n), .d(sdata), .q(sd_s));

    i2s_state_e            state_q, state_d;
    logic                  bclk_q;
    logic                  lr_prev, lr_prev_d;
    logic [audio_bits-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [audio_bits-1:0] left_buf, left_buf_d;
    logic                  have_left, have_left_d;
    logic [audio_bits-1:0] pcm_l_d, pcm_r_d;
    logic                  valid_d, frame_err_d;

    logic                  bit_ev;
    logic [CW-1:0]         cnt_inc;
    logic [CW-1:0]         pad;
    logic [audio_bits-1:0] shift_in;
    logic [audio_bits-1:0] word;
    logic                  short_word;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        lr_prev_d   = lr_prev;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        left_buf_d  = left_buf;
        have_left_d = have_left;
        pcm_l_d     = pcm_l;
        pcm_r_d     = pcm_r;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        bit_ev   = bclk_s & ~bclk_q;
        cnt_inc  = slot_cnt_inc(cnt_q);
        // Only the first audio_bits bits of a word enter the shifter.
        shift_in = (cnt_q < CW'(audio_bits)) ? {shift_q[audio_bits-2:0], sd_s} : shift_q;
        short_word = (cnt_inc < CW'(audio_bits));
        // Short words are left-justified with zero LSB padding.
        pad      = short_word ? CW'(CW'(audio_bits) - cnt_inc) : '0;
        word     = shift_in << pad;

        if (bit_ev) begin
            lr_prev_d = lr_s;
            if (lr_s != lr_prev) begin
                // Boundary bit is the LSB of the ending word.
                cnt_d   = '0;
                shift_d = '0;
                unique case (state_q)
                    HUNT: begin
                        state_d     = lr_s ? RIGHT : LEFT;
                        have_left_d = 1'b0;
                    end
                    LEFT: begin
                        if (lr_s) begin
                            left_buf_d  = word;
                            have_left_d = 1'b1;
                            frame_err_d = short_word;
                            state_d     = RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (!lr_s) begin
                            if (have_left) begin
                                pcm_l_d = left_buf;
                                pcm_r_d = word;
                                valid_d = 1'b1;
                            end
                            have_left_d = 1'b0;
                            frame_err_d = short_word;
                            state_d     = LEFT;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end else begin
                cnt_d   = cnt_inc;
                shift_d = shift_in;
                // Slot overrun: lose lock, keep the PCM outputs.
                if (state_q != HUNT && cnt_inc > CW'(slot_max)) begin
                    frame_err_d = 1'b1;
                    have_left_d = 1'b0;
                    state_d     = HUNT;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            bclk_q    <= 1'b0;
            lr_prev   <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            left_buf  <= '0;
            have_left <= 1'b0;
            pcm_l     <= '0;
            pcm_r     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bclk_q    <= bclk_s;
            lr_prev   <= lr_prev_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            left_buf  <= left_buf_d;
            have_left <= have_left_d;
            pcm_l     <= pcm_l_d;
            pcm_r     <= pcm_r_d;
            valid     <= valid_d;
            frame_err <= frame_err_d;
            locked    <= (state_d != HUNT);
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: word-level reference model plus
// directed literal checks.
module tb_i2s_receiver;

    localparam int W    = 16;
    localparam int SMAX = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         bclk = 1'b0;
    logic         lrclk = 1'b0;
    logic         sdata = 1'b0;
    logic [W-1:0] pcm_l, pcm_r;
    logic         valid, frame_err, locked;

    i2s_receiver #(.audio_bits(W), .slot_max(SMAX)) dut (
        .clk(clk), .reset_n(reset_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .valid(valid), .frame_err(frame_err),
        .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected output pulses, in order.
    typedef struct {
        bit           v;
        bit           e;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } ev_t;
    ev_t exp_q[$];

    logic [W-1:0] exp_l = '0;
    logic [W-1:0] exp_r = '0;

    // Word-level model: 0 = hunting, 1 = expecting left, 2 = expecting right.
    int           m_state = 0;
    bit           m_have = 1'b0;
    logic [W-1:0] m_left = '0;
    logic         m_lr_prev = 1'b0;

    int valid_cnt = 0;
    int err_cnt = 0;
    bit chk_en = 1'b0;
    int half = 4;
    bit jit = 1'b0;

    task automatic push_ev(input bit v, input bit e, input logic [W-1:0] l, input logic [W-1:0] r);
        ev_t ev;
        ev.v = v; ev.e = e; ev.l = l; ev.r = r;
        exp_q.push_back(ev);
    endtask

    // Predict the outputs produced by one slot of n bits sent with lrclk = ch,
    // whose last bit carries lrclk = nxt.
    task automatic model_slot(input logic ch, input logic nxt, input logic [63:0] bits, input int n);
        int           off;
        int           cnt;
        logic [W-1:0] val;
        bit           short_w;
        off = 0;
        if (m_lr_prev != ch) begin
            // lrclk already differs from the last sampled value: boundary on bit 0
            off = 1;
            m_have = 1'b0;
            m_state = ch ? 2 : 1;
        end
        cnt = n - off;
        if (m_state != 0 && cnt - 1 > SMAX) begin
            push_ev(1'b0, 1'b1, '0, '0);
            m_state = 0;
            m_have = 1'b0;
        end
        val = '0;
        for (int i = 0; i < W; i++)
            if (i < cnt) val[W-1-i] = bits[63-off-i];
        short_w = (cnt < W);
        case (m_state)
            0: m_state = nxt ? 2 : 1;
            1: begin
                m_left = val;
                m_have = 1'b1;
                if (short_w) push_ev(1'b0, 1'b1, '0, '0);
                m_state = 2;
            end
            default: begin
                if (m_have || short_w) push_ev(m_have, short_w, m_left, val);
                m_have = 1'b0;
                m_state = 1;
            end
        endcase
        m_lr_prev = nxt;
    endtask

    // Single compare process, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (valid) valid_cnt++;
            if (frame_err) err_cnt++;
            if (valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("valid_pulse", 32'(valid), 32'(e.v));
                    check("frame_err_pulse", 32'(frame_err), 32'(e.e));
                    if (e.v) begin
                        exp_l = e.l;
                        exp_r = e.r;
                    end
                end
            end
            check("pcm_l_track", 32'(pcm_l), 32'(exp_l));
            check("pcm_r_track", 32'(pcm_r), 32'(exp_r));
        end
    end

    function automatic logic [63:0] mk(input logic [31:0] v, input int width);
        return 64'(v) << (64 - width);
    endfunction

    task automatic send_bit(input logic lr, input logic sd);
        int lo, hi;
        lo = jit ? 2 + int'($urandom_range(0, 2)) : half;
        hi = jit ? 2 + int'($urandom_range(0, 2)) : half;
        bclk = 1'b0;
        lrclk = lr;
        sdata = sd;
        #(lo * 10);
        bclk = 1'b1;
        #(hi * 10);
    endtask

    task automatic send_slot(input logic ch, input logic nxt, input logic [63:0] bits, input int n);
        model_slot(ch, nxt, bits, n);
        for (int j = 0; j < n; j++)
            send_bit((j == n - 1) ? nxt : ch, bits[63-j]);
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int wbits, input int slot);
        send_slot(1'b0, 1'b1, mk(l, wbits), slot);
        send_slot(1'b1, 1'b0, mk(r, wbits), slot);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #2;
    endtask

    initial begin
        int v0, e0;
        logic [W-1:0] rl, rr;
        logic [63:0] lbits;

        repeat (3) @(posedge clk);
        #2;
        check("rst_pcm_l", 32'(pcm_l), 32'd0);
        check("rst_pcm_r", 32'(pcm_r), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // ~35x oversampled, 32-bit slots, three frames; first frame only locks.
        half = 18;
        v0 = valid_cnt;
        send_slot(1'b0, 1'b1, mk(32'h8001, W), 32);
        check("lock_after_first_boundary", 32'(locked), 32'd1);
        send_slot(1'b1, 1'b0, mk(32'h7FFE, W), 32);
        frame(32'h8001, 32'h7FFE, W, 32);
        frame(32'h8001, 32'h7FFE, W, 32);
        settle();
        check("three_frames_valid_count", 32'(valid_cnt - v0), 32'd2);
        check("three_frames_pcm_l", 32'(pcm_l), 32'h8001);
        check("three_frames_pcm_r", 32'(pcm_r), 32'h7FFE);

        // 16-bit slots.
        half = 4;
        e0 = err_cnt;
        v0 = valid_cnt;
        frame(32'h1234, 32'hABCD, W, 16);
        frame(32'h1234, 32'hABCD, W, 16);
        settle();
        check("slot16_no_err", 32'(err_cnt - e0), 32'd0);
        check("slot16_valid_count", 32'(valid_cnt - v0), 32'd2);
        check("slot16_pcm_l", 32'(pcm_l), 32'h1234);
        check("slot16_pcm_r", 32'(pcm_r), 32'hABCD);

        // 12-bit slots: every word short, zero-padded.
        e0 = err_cnt;
        frame(32'hFFF, 32'h5A5, 12, 12);
        frame(32'hFFF, 32'h5A5, 12, 12);
        settle();
        check("slot12_err_count", 32'(err_cnt - e0), 32'd4);
        check("slot12_pcm_l", 32'(pcm_l), 32'hFFF0);
        check("slot12_pcm_r", 32'(pcm_r), 32'h5A50);

        // lrclk held low for 40 bits: overrun at the 33rd bit.
        frame(32'h1111, 32'h2222, W, 16);
        settle();
        e0 = err_cnt;
        lbits = mk(32'h3333, W);
        model_slot(1'b0, 1'b1, lbits, 41);
        for (int j = 0; j < 41; j++) begin
            send_bit((j == 40) ? 1'b1 : 1'b0, lbits[63-j]);
            if (j == 36) check("overrun_locked_low", 32'(locked), 32'd0);
        end
        settle();
        check("overrun_err_count", 32'(err_cnt - e0), 32'd1);
        check("overrun_pcm_l_hold", 32'(pcm_l), 32'h1111);
        check("overrun_pcm_r_hold", 32'(pcm_r), 32'h2222);
        check("overrun_relock", 32'(locked), 32'd1);
        v0 = valid_cnt;
        send_slot(1'b1, 1'b0, mk(32'h9999, W), 16);
        settle();
        check("overrun_orphan_right_no_valid", 32'(valid_cnt - v0), 32'd0);
        frame(32'h4444, 32'h5555, W, 16);
        settle();
        check("overrun_recover_pcm_l", 32'(pcm_l), 32'h4444);
        check("overrun_recover_pcm_r", 32'(pcm_r), 32'h5555);

        // Reset pulse in the middle of a right word.
        send_slot(1'b0, 1'b1, mk(32'h6666, W), 16);
        for (int j = 0; j < 4; j++) send_bit(1'b1, j[0]);
        bclk = 1'b0;
        #(half * 10);
        reset_n = 1'b0;
        exp_q.delete();
        m_state = 0;
        m_have = 1'b0;
        m_lr_prev = 1'b0;
        exp_l = '0;
        exp_r = '0;
        repeat (2) @(posedge clk);
        #2;
        check("midword_rst_pcm_l", 32'(pcm_l), 32'd0);
        check("midword_rst_pcm_r", 32'(pcm_r), 32'd0);
        check("midword_rst_locked", 32'(locked), 32'd0);
        reset_n = 1'b1;
        v0 = valid_cnt;
        send_slot(1'b1, 1'b0, mk(32'h0F0F, W), 12);
        settle();
        check("midword_rst_no_valid_yet", 32'(valid_cnt - v0), 32'd0);
        frame(32'h7777, 32'h8888, W, 16);
        settle();
        check("midword_rst_valid_after_frame", 32'(valid_cnt - v0), 32'd1);
        check("midword_rst_pcm_l", 32'(pcm_l), 32'h7777);
        check("midword_rst_pcm_r", 32'(pcm_r), 32'h8888);

        // Jittered BCLK around 4x oversampling, random samples.
        jit = 1'b1;
        v0 = valid_cnt;
        for (int f = 0; f < 150; f++) begin
            rl = W'($urandom);
            rr = W'($urandom);
            frame(32'(rl), 32'(rr), W, 16);
        end
        jit = 1'b0;
        settle();
        check("jitter_valid_count", 32'(valid_cnt - v0), 32'd150);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
